// File: rtl/ccc_apb_cfg_master.sv
// APB3 initiator for the CCC dynamic-configuration port.
// Runs single read/write commands, optionally waiting for LOCK to resettle.
module ccc_apb_cfg_master #(
  parameter int SETTLE_CYC  = 16,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WRITE,
  input  logic [5:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  input  logic       CMD_WAIT_LOCK,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic       BUSY,
  output logic       LOCK_S,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       LOCK
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] SETTLE_W  = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] TIMEOUT_W = CW'(TIMEOUT_CYC);
  localparam logic [SW-1:0] STABLE_W  = SW'(STABLE_CYC);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    LOCK_WAIT,
    RESP
  } state_t;

  state_t        state;
  logic          lock_s1;
  logic          lock_s2;
  logic          wait_lock;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] stable_cnt;
  logic          lock_ok;
  logic          lock_tmo;

  assign CMD_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign LOCK_S    = lock_s2;

  // Decisions use the registered counters, one cycle behind the count.
  assign lock_ok  = (wait_cnt >= SETTLE_W) && (stable_cnt == STABLE_W);
  assign lock_tmo = (wait_cnt == TIMEOUT_W);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= LOCK;
      lock_s2 <= lock_s1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      RSP_VALID  <= 1'b0;
      RSP_ERR    <= 1'b0;
      RSP_RDATA  <= '0;
      wait_lock  <= 1'b0;
      wait_cnt   <= '0;
      stable_cnt <= '0;
    end else begin
      RSP_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CMD_VALID) begin
            PWRITE    <= CMD_WRITE;
            PADDR     <= CMD_ADDR;
            PWDATA    <= CMD_WDATA;
            wait_lock <= CMD_WAIT_LOCK & CMD_WRITE;
            RSP_ERR   <= 1'b0;
            PSEL      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          RSP_RDATA <= PWRITE ? 8'h00 : PRDATA;
          if (PWRITE && wait_lock) begin
            wait_cnt   <= '0;
            stable_cnt <= '0;
            state      <= LOCK_WAIT;
          end else begin
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end
        end
        LOCK_WAIT: begin
          if (!lock_tmo) wait_cnt <= wait_cnt + CW'(1);
          if (!lock_s2) stable_cnt <= '0;
          else if (stable_cnt != STABLE_W) stable_cnt <= stable_cnt + SW'(1);
          if (lock_ok) begin
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
            state     <= RESP;
          end else if (lock_tmo) begin
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Directed bench for ccc_apb_cfg_master.
// Inputs change and outputs are sampled on the falling edge.
module tb_ccc_apb_cfg_master;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_WRITE = 1'b0;
  logic [5:0] CMD_ADDR = '0;
  logic [7:0] CMD_WDATA = '0;
  logic       CMD_WAIT_LOCK = 1'b0;
  logic [7:0] PRDATA = '0;
  logic       LOCK = 1'b0;
  logic       CMD_READY;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       RSP_ERR;
  logic       BUSY;
  logic       LOCK_S;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA;

  int total = 0;
  int bad = 0;

  ccc_apb_cfg_master #(
    .SETTLE_CYC(16),
    .STABLE_CYC(4),
    .TIMEOUT_CYC(64)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA),
    .CMD_WAIT_LOCK(CMD_WAIT_LOCK),
    .RSP_VALID(RSP_VALID),
    .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR),
    .BUSY(BUSY),
    .LOCK_S(LOCK_S),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .LOCK(LOCK)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // Presents a command in cycle T and returns in cycle T+1.
  task automatic launch(input logic w, input logic [5:0] a,
                        input logic [7:0] d, input logic wl);
    CMD_VALID = 1'b1;
    CMD_WRITE = w;
    CMD_ADDR = a;
    CMD_WDATA = d;
    CMD_WAIT_LOCK = wl;
    chk("ready_at_T", CMD_READY, 1);
    cyc(1);
    CMD_VALID = 1'b0;
  endtask

  // From T+1, runs to cycle T+n expecting the response there and
  // nowhere earlier; LOCK is driven low/high in cycles drop/rise.
  task automatic wait_rsp(input string tag, input int n, input logic err,
                          input int drop, input int rise);
    int early;
    early = 0;
    for (int c = 2; c <= n; c++) begin
      cyc(1);
      if (c < n && RSP_VALID) early++;
      if (c == drop) LOCK = 1'b0;
      if (c == rise) LOCK = 1'b1;
    end
    chk({tag, "_early"}, early, 0);
    chk({tag, "_valid"}, RSP_VALID, 1);
    chk({tag, "_err"}, RSP_ERR, err);
    chk({tag, "_rdata"}, RSP_RDATA, 8'h00);
    chk({tag, "_psel"}, PSEL, 0);
  endtask

  initial begin
    int cnt;
    #1;
    chk("rst_ready", CMD_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_pen", PENABLE, 0);
    chk("rst_paddr", PADDR, 6'h00);
    chk("rst_rspv", RSP_VALID, 0);
    chk("rst_lock_s", LOCK_S, 0);
    LOCK = 1'b1;
    cyc(2);
    chk("rst_lock_s_held", LOCK_S, 0);
    PRESET = 1'b0;
    cyc(4);
    chk("lock_s_sync", LOCK_S, 1);

    // Write without lock wait.
    launch(1'b1, 6'h05, 8'hA5, 1'b0);
    chk("wr_t1_psel", PSEL, 1);
    chk("wr_t1_pen", PENABLE, 0);
    chk("wr_t1_paddr", PADDR, 6'h05);
    chk("wr_t1_pwdata", PWDATA, 8'hA5);
    chk("wr_t1_pwrite", PWRITE, 1);
    chk("wr_t1_busy", BUSY, 1);
    chk("wr_t1_ready", CMD_READY, 0);
    cyc(1);
    chk("wr_t2_psel", PSEL, 1);
    chk("wr_t2_pen", PENABLE, 1);
    cyc(1);
    chk("wr_t3_psel", PSEL, 0);
    chk("wr_t3_pen", PENABLE, 0);
    chk("wr_t3_rspv", RSP_VALID, 1);
    chk("wr_t3_rdata", RSP_RDATA, 8'h00);
    chk("wr_t3_err", RSP_ERR, 0);
    chk("wr_t3_paddr_hold", PADDR, 6'h05);
    cyc(1);
    chk("wr_t4_ready", CMD_READY, 1);
    chk("wr_t4_rspv", RSP_VALID, 0);

    // Read; wait-lock request must be ignored.
    PRDATA = 8'h3C;
    launch(1'b0, 6'h2A, 8'hFF, 1'b1);
    chk("rd_t1_pwrite", PWRITE, 0);
    chk("rd_t1_paddr", PADDR, 6'h2A);
    cyc(1);
    chk("rd_t2_pwrite", PWRITE, 0);
    chk("rd_t2_pen", PENABLE, 1);
    cyc(1);
    chk("rd_t3_rspv", RSP_VALID, 1);
    chk("rd_t3_rdata", RSP_RDATA, 8'h3C);
    cyc(1);
    chk("rd_t4_ready", CMD_READY, 1);

    // Lock dips and recovers; sampled low from edge T+5, high from T+40.
    launch(1'b1, 6'h10, 8'h44, 1'b1);
    wait_rsp("lockdip", 46, 1'b0, 4, 39);
    cyc(1);
    chk("lockdip_idle", CMD_READY, 1);

    // Lock held low: timeout after 64 wait cycles.
    LOCK = 1'b0;
    cyc(3);
    launch(1'b1, 6'h11, 8'h12, 1'b1);
    wait_rsp("tmo", 68, 1'b1, -1, -1);
    cyc(1);
    chk("tmo_err_held", RSP_ERR, 1);
    PRDATA = 8'h77;
    launch(1'b0, 6'h01, 8'h00, 1'b0);
    chk("tmo_err_clr", RSP_ERR, 0);
    cyc(2);
    chk("rd2_rdata", RSP_RDATA, 8'h77);
    chk("rd2_err", RSP_ERR, 0);
    cyc(1);

    // Lock high throughout: settle time dominates.
    LOCK = 1'b1;
    cyc(3);
    launch(1'b1, 6'h12, 8'h34, 1'b1);
    wait_rsp("settle", 20, 1'b0, -1, -1);
    cyc(1);

    // Back-to-back with CMD_VALID held high.
    PRDATA = 8'h9D;
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR = 6'h07;
    CMD_WDATA = 8'h11;
    CMD_WAIT_LOCK = 1'b0;
    cyc(1);
    CMD_WRITE = 1'b0;
    CMD_ADDR = 6'h08;
    chk("b2b_t1_paddr", PADDR, 6'h07);
    cyc(2);
    chk("b2b_t3_rspv", RSP_VALID, 1);
    cyc(1);
    chk("b2b_t4_ready", CMD_READY, 1);
    chk("b2b_t4_psel", PSEL, 0);
    cyc(1);
    CMD_VALID = 1'b0;
    chk("b2b_t5_psel", PSEL, 1);
    chk("b2b_t5_pen", PENABLE, 0);
    chk("b2b_t5_paddr", PADDR, 6'h08);
    chk("b2b_t5_pwrite", PWRITE, 0);
    cyc(2);
    chk("b2b_t7_rspv", RSP_VALID, 1);
    chk("b2b_t7_rdata", RSP_RDATA, 8'h9D);
    cyc(1);

    // Reset pulse during ACCESS.
    launch(1'b0, 6'h2A, 8'h00, 1'b0);
    cyc(1);
    chk("rst_mid_pen_before", PENABLE, 1);
    PRESET = 1'b1;
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_pen", PENABLE, 0);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_ready", CMD_READY, 1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (RSP_VALID) cnt++;
    end
    PRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (RSP_VALID) cnt++;
    end
    chk("rst_mid_no_rsp", cnt, 0);
    PRDATA = 8'h5E;
    launch(1'b0, 6'h11, 8'h00, 1'b0);
    chk("post_rst_paddr", PADDR, 6'h11);
    cyc(2);
    chk("post_rst_rspv", RSP_VALID, 1);
    chk("post_rst_rdata", RSP_RDATA, 8'h5E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccc_apb_cfg_master.md
Name: ccc_apb_cfg_master

Overview:
- APB3 initiator that drives the dynamic-configuration APB port of a fabric CCC: PSEL/PENABLE/PWRITE/PADDR[5:0]/PWDATA[7:0] out, PRDATA[7:0] in.
- Accepts single read/write commands from fabric logic over a valid/ready handshake and returns one response pulse per command.
- After a configuration write it can wait for the CCC LOCK output to resettle, flagging a timeout error if it does not.
- Sits between the system controller logic and the CCC instance, in the same clock domain as the CCC APB PCLK.

Parameters:
- SETTLE_CYC, 16, minimum cycles spent in lock-wait before success is allowed.
- STABLE_CYC, 4, consecutive cycles the synchronised LOCK must be high to count as locked.
- TIMEOUT_CYC, 1024, lock-wait cycles before a timeout error is reported.

Ports:
- PCLK  in  1  single clock for all logic and the APB interface.
- PRESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  6  CCC register address.
- CMD_WDATA  in  8  write data.
- CMD_WAIT_LOCK  in  1  write only: wait for LOCK after the transfer.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  8  read data; 0x00 for writes.
- RSP_ERR  out  1  lock-wait timeout; valid with RSP_VALID.
- BUSY  out  1  state != IDLE.
- LOCK_S  out  1  synchronised LOCK.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  6  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- LOCK  in  1  CCC lock; asynchronous, passes through a 2-flop synchroniser to LOCK_S.

Behaviour:
- Reset (asynchronous): state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR=0; PWDATA=0; RSP_VALID, RSP_ERR=0; RSP_RDATA=0; synchroniser flops=0; counters=0.
- CMD_READY decodes IDLE, so it reads 1 during reset. No command is accepted while PRESET is high.
- Reset asserted mid-operation: all outputs return to reset values immediately. The in-flight command is dropped and produces no response.
- States: IDLE, SETUP, ACCESS, LOCK_WAIT, RESP.
- IDLE: on the edge where CMD_VALID & CMD_READY, register CMD_WRITE/ADDR/WDATA/WAIT_LOCK into PWRITE/PADDR/PWDATA/wait flag, then go to SETUP. Command inputs are ignored in all other states.
- SETUP (1 cycle): PSEL=1, PENABLE=0; then go to ACCESS.
- ACCESS (1 cycle, no PREADY): PSEL=1, PENABLE=1.
  - On the exiting edge, capture PRDATA into RSP_RDATA for reads; load 0x00 for writes.
  - Next state: LOCK_WAIT if write & wait flag, else RESP.
- APB address, data and direction hold their values after a transfer until the next accept. PSEL and PENABLE are 0 outside SETUP/ACCESS.
- LOCK_WAIT:
  - wait_cnt clears on entry and increments each cycle, saturating at TIMEOUT_CYC.
  - stable_cnt clears whenever LOCK_S=0; otherwise it increments, saturating at STABLE_CYC.
  - Success: wait_cnt>=SETTLE_CYC and stable_cnt==STABLE_CYC. Go to RESP with ERR=0.
  - Timeout: wait_cnt==TIMEOUT_CYC without success. Go to RESP with ERR=1.
  - If success and timeout occur in the same cycle, success wins.
  - Counter width is clog2(TIMEOUT_CYC+1).
- RESP (1 cycle): RSP_VALID=1, and RSP_ERR/RSP_RDATA are valid. There is no backpressure. Next state is IDLE.
- RSP_ERR clears on the next accept.
- Minimum command period is 4 cycles: accept at T; SETUP T+1; ACCESS T+2; RESP T+3; IDLE T+4. PSEL is low for at least 2 cycles between transfers.
- CMD_WAIT_LOCK is ignored on reads.

Test Plan:
- Write, no wait: accept ADDR=0x05, WDATA=0xA5 at T -> T+1 PSEL=1, PENABLE=0, PADDR=05, PWDATA=A5, PWRITE=1; T+2 PENABLE=1; T+3 PSEL=0, RSP_VALID=1, RSP_RDATA=00, RSP_ERR=0; CMD_READY=1 at T+4.
- Read: ADDR=0x2A with PRDATA=0x3C during ACCESS -> RSP_RDATA=0x3C, RSP_VALID at T+3; PWRITE=0 through the transfer.
- Write with wait: LOCK drops at T+5 and rises at T+40, stays high -> RSP_VALID=1, RSP_ERR=0 in cycle T+46; no earlier response.
- Timeout: TIMEOUT_CYC=64, LOCK held low -> RSP_VALID=1, RSP_ERR=1 at T+68; next command clears RSP_ERR.
- LOCK high throughout a wait: SETTLE_CYC=16 -> success, RSP_VALID at T+20.
- Back-to-back: CMD_VALID held high with two commands -> second accept at T+4, its SETUP at T+5.
- Reset pulse during ACCESS -> PSEL and PENABLE drop without a clock edge; no RSP_VALID; a subsequent read completes normally.
